// File: rtl/config_reg_bank_pkg.sv
// Shared constants for config_reg_bank: CTRL/CMD register offsets, command codes
// and the write-classification type used by the address decoder.
package config_reg_bank_pkg;

  localparam int unsigned CTRL_OFF = 0;
  localparam int unsigned CMD_OFF  = 1;

  localparam logic [15:0] CTRL_TRG_SET = 16'h0001;
  localparam logic [15:0] CTRL_TRG_CLR = 16'h0000;
  localparam logic [15:0] CTRL_DT_SET  = 16'h0002;
  localparam logic [15:0] CTRL_DT_CLR  = 16'h0003;

  localparam logic [15:0] CMD_RST_PULSE = 16'h0055;
  localparam logic [15:0] CMD_TRG_PULSE = 16'h0060;
  localparam logic [15:0] CMD_LOCK      = 16'h00AA;
  localparam logic [15:0] CMD_UNLOCK    = 16'h0033;
  localparam logic [15:0] CMD_COMMIT    = 16'h00A5;

  typedef enum logic [2:0] {
    WR_NONE,
    WR_CTRL,
    WR_CMD,
    WR_DATA,
    WR_REJECT
  } wr_kind_e;

endpackage

// File: rtl/cmd_pulse_gen.sv
// Fixed-length pulse generator: a start while idle drives pulse_out high for
// exactly PULSE_LEN cycles beginning the next cycle; starts while busy are ignored.
module cmd_pulse_gen #(
  parameter int PULSE_LEN = 50
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic start_in,
  output logic pulse_out
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (start_in) begin
      r_cnt <= CW'(PULSE_LEN);
    end
  end

  assign pulse_out = (r_cnt != '0);

endmodule

// File: rtl/config_reg_bank.sv
// Configuration register bank with CTRL/CMD decode, lockable data registers and
// command pulses. Define CFG_SHADOW_EN to stage data writes in a shadow image.
module config_reg_bank
  import config_reg_bank_pkg::*;
#(
  parameter int                     NUM_REGS  = 20,
  parameter int                     DW        = 16,
  parameter int                     AW        = 8,
  parameter logic [AW-1:0]          BASE_ADDR = 'h02,
  parameter int                     PULSE_LEN = 50,
  parameter logic [NUM_REGS*DW-1:0] RST_VALS  = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     wr_in,
  input  logic [AW-1:0]            wr_addr_in,
  input  logic [DW-1:0]            data_in,
  input  logic                     rd_in,
  input  logic [AW-1:0]            rd_addr_in,
  output logic [DW-1:0]            rd_data_out,
  output logic                     rd_valid_out,
  output logic [NUM_REGS*DW-1:0]   cfg_flat_out,
  output logic                     trg_enb_out,
  output logic                     data_trans_enb_out,
  output logic                     locked_out,
  output logic                     cmd_rst_out,
  output logic                     cycled_trg_bgn_out,
  output logic                     commit_out,
  output logic [15:0]              config_received_out,
  output logic [7:0]               wr_reject_cnt_out
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DW-1:0] r_active [NUM_REGS];
`ifdef CFG_SHADOW_EN
  logic [DW-1:0] r_shadow [NUM_REGS];
`endif

  logic          r_trg_enb;
  logic          r_dt_enb;
  logic          r_locked;
  logic          r_commit;
  logic          r_wr_d;
  logic [15:0]   r_cfg_rx;
  logic [7:0]    r_rej_cnt;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;

  logic [AW:0]   w_wr_rel;
  logic [AW:0]   w_rd_rel;
  logic          w_wr_in_rng;
  logic          w_rd_in_rng;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  wr_kind_e      w_wr_kind;
  logic          w_cmd_wr;
  logic          w_commit_hit;
  logic          w_start_rst;
  logic          w_start_trg;

  // One extra bit so addresses below BASE_ADDR wrap negative and fail the range test
  assign w_wr_rel    = {1'b0, wr_addr_in} - {1'b0, BASE_ADDR};
  assign w_rd_rel    = {1'b0, rd_addr_in} - {1'b0, BASE_ADDR};
  assign w_wr_in_rng = !w_wr_rel[AW] && (w_wr_rel < (AW+1)'(NUM_REGS));
  assign w_rd_in_rng = !w_rd_rel[AW] && (w_rd_rel < (AW+1)'(NUM_REGS));
  assign w_wr_idx    = IW'(w_wr_rel);
  assign w_rd_idx    = IW'(w_rd_rel);

  always_comb begin
    w_wr_kind = WR_NONE;
    if (wr_in) begin
      if (!w_wr_in_rng)                    w_wr_kind = WR_REJECT;
      else if (w_wr_idx == IW'(CTRL_OFF))  w_wr_kind = WR_CTRL;
      else if (w_wr_idx == IW'(CMD_OFF))   w_wr_kind = WR_CMD;
      else if (r_locked)                   w_wr_kind = WR_REJECT;
      else                                 w_wr_kind = WR_DATA;
    end
  end

  assign w_cmd_wr     = (w_wr_kind == WR_CMD);
  assign w_commit_hit = w_cmd_wr && (data_in == DW'(CMD_COMMIT));
  assign w_start_rst  = w_cmd_wr && (data_in == DW'(CMD_RST_PULSE));
  assign w_start_trg  = w_cmd_wr && (data_in == DW'(CMD_TRG_PULSE));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_active[i] <= RST_VALS[i*DW +: DW];
`ifdef CFG_SHADOW_EN
        r_shadow[i] <= RST_VALS[i*DW +: DW];
`endif
      end
    end else begin
`ifdef CFG_SHADOW_EN
      // Copy uses pre-edge shadow contents, so a coincident write is not committed
      if (w_commit_hit) begin
        for (int i = 2; i < NUM_REGS; i++) r_active[i] <= r_shadow[i];
      end
      if (w_wr_kind == WR_DATA) r_shadow[w_wr_idx] <= data_in;
`else
      if (w_wr_kind == WR_DATA) r_active[w_wr_idx] <= data_in;
`endif
      if (w_wr_kind == WR_CTRL || w_wr_kind == WR_CMD) r_active[w_wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_trg_enb <= 1'b0;
      r_dt_enb  <= 1'b0;
      r_locked  <= 1'b0;
      r_commit  <= 1'b0;
    end else begin
      r_commit <= w_commit_hit;
      if (w_wr_kind == WR_CTRL) begin
        if (data_in == DW'(CTRL_TRG_SET))      r_trg_enb <= 1'b1;
        else if (data_in == DW'(CTRL_TRG_CLR)) r_trg_enb <= 1'b0;
        else if (data_in == DW'(CTRL_DT_SET))  r_dt_enb  <= 1'b1;
        else if (data_in == DW'(CTRL_DT_CLR))  r_dt_enb  <= 1'b0;
      end
      if (w_cmd_wr && data_in == DW'(CMD_LOCK))   r_locked <= 1'b1;
      if (w_cmd_wr && data_in == DW'(CMD_UNLOCK)) r_locked <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_d    <= 1'b0;
      r_cfg_rx  <= '0;
      r_rej_cnt <= '0;
    end else begin
      r_wr_d <= wr_in;
      if (wr_in && !r_wr_d && w_wr_in_rng && r_cfg_rx != 16'hFFFF) r_cfg_rx <= r_cfg_rx + 1'b1;
      if (w_wr_kind == WR_REJECT && r_rej_cnt != 8'hFF) r_rej_cnt <= r_rej_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_in;
      if (rd_in) r_rd_data <= w_rd_in_rng ? r_active[w_rd_idx] : '0;
    end
  end

  cmd_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_rst_pulse (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .start_in  (w_start_rst),
    .pulse_out (cmd_rst_out)
  );

  cmd_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_trg_pulse (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .start_in  (w_start_trg),
    .pulse_out (cycled_trg_bgn_out)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_flat_out[g*DW +: DW] = r_active[g];
  end

  assign rd_data_out         = r_rd_data;
  assign rd_valid_out        = r_rd_valid;
  assign trg_enb_out         = r_trg_enb;
  assign data_trans_enb_out  = r_dt_enb;
  assign locked_out          = r_locked;
  assign commit_out          = r_commit;
  assign config_received_out = r_cfg_rx;
  assign wr_reject_cnt_out   = r_rej_cnt;

endmodule

// File: tb/tb_config_reg_bank.sv
// Directed bench for config_reg_bank: vector table for decode/flags/reads, plus
// hand sequences for pulse length, retrigger, commit strobe and async reset.
module tb_config_reg_bank;

  localparam int NR = 20;
  localparam int DW = 16;

`ifdef CFG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  function automatic logic [NR*DW-1:0] mk_rst();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = 16'hA000 + 16'(i);
    return r;
  endfunction

  localparam logic [NR*DW-1:0] TB_RST = mk_rst();

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              wr_in;
  logic [7:0]        wr_addr_in;
  logic [15:0]       data_in;
  logic              rd_in;
  logic [7:0]        rd_addr_in;
  logic [15:0]       rd_data_out;
  logic              rd_valid_out;
  logic [NR*DW-1:0]  cfg_flat_out;
  logic              trg_enb_out;
  logic              data_trans_enb_out;
  logic              locked_out;
  logic              cmd_rst_out;
  logic              cycled_trg_bgn_out;
  logic              commit_out;
  logic [15:0]       config_received_out;
  logic [7:0]        wr_reject_cnt_out;

  config_reg_bank #(.RST_VALS(TB_RST)) dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .wr_in               (wr_in),
    .wr_addr_in          (wr_addr_in),
    .data_in             (data_in),
    .rd_in               (rd_in),
    .rd_addr_in          (rd_addr_in),
    .rd_data_out         (rd_data_out),
    .rd_valid_out        (rd_valid_out),
    .cfg_flat_out        (cfg_flat_out),
    .trg_enb_out         (trg_enb_out),
    .data_trans_enb_out  (data_trans_enb_out),
    .locked_out          (locked_out),
    .cmd_rst_out         (cmd_rst_out),
    .cycled_trg_bgn_out  (cycled_trg_bgn_out),
    .commit_out          (commit_out),
    .config_received_out (config_received_out),
    .wr_reject_cnt_out   (wr_reject_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    bit          trg;
    bit          dt;
    bit          lk;
    bit          cm;
    logic [7:0]  rej;
    logic [15:0] rx;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t vw(logic [7:0] a, logic [15:0] d, bit trg, bit dt, bit lk,
                              bit cm, logic [7:0] rej, logic [15:0] rx);
    vec_t v;
    v.is_wr = 1'b1; v.addr = a; v.data = d; v.exp_rd = '0;
    v.trg = trg; v.dt = dt; v.lk = lk; v.cm = cm; v.rej = rej; v.rx = rx;
    return v;
  endfunction

  function automatic vec_t vr(logic [7:0] a, logic [15:0] e);
    vec_t v;
    v.is_wr = 1'b0; v.addr = a; v.data = '0; v.exp_rd = e;
    v.trg = 1'b0; v.dt = 1'b0; v.lk = 1'b0; v.cm = 1'b0; v.rej = '0; v.rx = '0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [15:0] d);
    wr_addr_in = a; data_in = d; wr_in = 1'b1;
    tick();
    wr_in = 1'b0;
    tick();
  endtask

  int hi, last, first, any_other, cm_cnt;

  initial begin
    rst_n_in = 1'b0; wr_in = 1'b0; wr_addr_in = '0; data_in = '0;
    rd_in = 1'b0; rd_addr_in = '0;
    tick(); tick();

    chk("rst_trg", trg_enb_out, 0);
    chk("rst_dt", data_trans_enb_out, 0);
    chk("rst_lock", locked_out, 0);
    chk("rst_rx", config_received_out, 0);
    chk("rst_rej", wr_reject_cnt_out, 0);
    chk("rst_valid", rd_valid_out, 0);
    chk("rst_flat", cfg_flat_out == TB_RST, 1);

    #2 rst_n_in = 1'b1;
    tick();

    vq.push_back(vw(8'h02, 16'h0001, 1, 0, 0, 0, 0, 1));
    vq.push_back(vw(8'h02, 16'h0002, 1, 1, 0, 0, 0, 2));
    vq.push_back(vw(8'h02, 16'h0000, 0, 1, 0, 0, 0, 3));
    vq.push_back(vw(8'h02, 16'h0007, 0, 1, 0, 0, 0, 4));
    vq.push_back(vw(8'h02, 16'h0003, 0, 0, 0, 0, 0, 5));
    vq.push_back(vr(8'h02, 16'h0003));
    vq.push_back(vw(8'h04, 16'h1234, 0, 0, 0, 0, 0, 6));
    vq.push_back(vr(8'h04, SHADOW ? 16'hA002 : 16'h1234));
    vq.push_back(vw(8'h03, 16'h00A5, 0, 0, 0, 1, 0, 7));
    vq.push_back(vr(8'h04, 16'h1234));
    vq.push_back(vw(8'h03, 16'h00AA, 0, 0, 1, 0, 0, 8));
    vq.push_back(vw(8'h05, 16'hBEEF, 0, 0, 1, 0, 1, 9));
    vq.push_back(vw(8'h03, 16'h00A5, 0, 0, 1, 1, 1, 10));
    vq.push_back(vr(8'h05, 16'hA003));
    vq.push_back(vw(8'h02, 16'h0001, 1, 0, 1, 0, 1, 11));
    vq.push_back(vw(8'h16, 16'h1111, 1, 0, 1, 0, 2, 11));
    vq.push_back(vw(8'h01, 16'h2222, 1, 0, 1, 0, 3, 11));
    vq.push_back(vr(8'h16, 16'h0000));
    vq.push_back(vr(8'h15, 16'hA013));
    vq.push_back(vr(8'h01, 16'h0000));
    vq.push_back(vw(8'h03, 16'h0033, 1, 0, 0, 0, 3, 12));
    vq.push_back(vw(8'h15, 16'h5A5A, 1, 0, 0, 0, 3, 13));
    vq.push_back(vw(8'h03, 16'h00A5, 1, 0, 0, 1, 3, 14));
    vq.push_back(vr(8'h15, 16'h5A5A));
    vq.push_back(vr(8'h03, 16'h00A5));

    foreach (vq[i]) begin
      if (vq[i].is_wr) begin
        wr_addr_in = vq[i].addr; data_in = vq[i].data; wr_in = 1'b1;
        tick();
        wr_in = 1'b0;
        chk($sformatf("v%0d_trg", i), trg_enb_out, vq[i].trg);
        chk($sformatf("v%0d_dt", i), data_trans_enb_out, vq[i].dt);
        chk($sformatf("v%0d_lock", i), locked_out, vq[i].lk);
        chk($sformatf("v%0d_commit", i), commit_out, vq[i].cm);
        chk($sformatf("v%0d_rej", i), wr_reject_cnt_out, vq[i].rej);
        chk($sformatf("v%0d_rx", i), config_received_out, vq[i].rx);
        chk($sformatf("v%0d_pulses", i), {cmd_rst_out, cycled_trg_bgn_out}, 0);
        tick();
      end else begin
        rd_addr_in = vq[i].addr; rd_in = 1'b1;
        tick();
        rd_in = 1'b0;
        chk($sformatf("v%0d_rdata", i), rd_data_out, vq[i].exp_rd);
        chk($sformatf("v%0d_rvalid", i), rd_valid_out, 1);
        tick();
      end
    end
    chk("flat_off2", cfg_flat_out[2*DW +: DW], 16'h1234);

    // cmd_rst pulse: length, next-cycle start, retrigger at sample 10 ignored
    wr_addr_in = 8'h03; data_in = 16'h0055; wr_in = 1'b1;
    tick();
    wr_in = 1'b0;
    hi = 0; last = -1; first = int'(cmd_rst_out); any_other = 0;
    for (int k = 0; k < 100; k++) begin
      if (cmd_rst_out) begin hi++; last = k; end
      if (cycled_trg_bgn_out) any_other = 1;
      wr_in = (k == 10);
      tick();
    end
    wr_in = 1'b0;
    chk("rstp_first", first, 1);
    chk("rstp_len", hi, 50);
    chk("rstp_last", last, 49);
    chk("rstp_other", any_other, 0);

    data_in = 16'h0060; wr_in = 1'b1;
    tick();
    wr_in = 1'b0;
    hi = 0; first = int'(cycled_trg_bgn_out); any_other = 0;
    for (int k = 0; k < 60; k++) begin
      if (cycled_trg_bgn_out) hi++;
      if (cmd_rst_out) any_other = 1;
      tick();
    end
    chk("trgp_first", first, 1);
    chk("trgp_len", hi, 50);
    chk("trgp_other", any_other, 0);

    data_in = 16'h00A5; wr_in = 1'b1;
    tick();
    wr_in = 1'b0;
    cm_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (commit_out) cm_cnt++;
      tick();
    end
    chk("commit_once", cm_cnt, 1);
    chk("rx_after_cmds", config_received_out, 18);

    // Held strobe counts once
    wr_addr_in = 8'h02; data_in = 16'h0001; wr_in = 1'b1;
    tick(); tick(); tick();
    wr_in = 1'b0;
    tick();
    chk("hold_rx", config_received_out, 19);
    chk("hold_rej", wr_reject_cnt_out, 3);

    do_wr(8'h03, 16'h00AA);
    wr_addr_in = 8'h03; data_in = 16'h0055; wr_in = 1'b1;
    tick();
    wr_in = 1'b0;
    tick(); tick(); tick(); tick();
    rd_addr_in = 8'h04; rd_in = 1'b1;
    tick();
    rd_in = 1'b0;
    chk("pre_valid", rd_valid_out, 1);
    chk("pre_rdata", rd_data_out, 16'h1234);
    chk("pre_pulse", cmd_rst_out, 1);
    chk("pre_lock", locked_out, 1);
    chk("pre_trg", trg_enb_out, 1);
    chk("pre_rx", config_received_out, 21);

    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_pulse", cmd_rst_out, 0);
    chk("arst_trgp", cycled_trg_bgn_out, 0);
    chk("arst_lock", locked_out, 0);
    chk("arst_trg", trg_enb_out, 0);
    chk("arst_dt", data_trans_enb_out, 0);
    chk("arst_commit", commit_out, 0);
    chk("arst_rx", config_received_out, 0);
    chk("arst_rej", wr_reject_cnt_out, 0);
    chk("arst_valid", rd_valid_out, 0);
    chk("arst_rdata", rd_data_out, 0);
    chk("arst_flat", cfg_flat_out == TB_RST, 1);

    tick();
    #2 rst_n_in = 1'b1;
    tick();
    rd_addr_in = 8'h04; rd_in = 1'b1;
    tick();
    rd_in = 1'b0;
    chk("post_rdata", rd_data_out, 16'hA002);
    chk("post_pulse", cmd_rst_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
